// File: rtl/imm_gen_pipe_if.sv
// Decode-to-execute immediate channel: instruction/format/PC in, extended immediate/PC/illegal out.
// Latency: none (signal bundle only).
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
interface imm_gen_pipe_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [24:0]     instr;
    logic [2:0]      ImmSrc;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] ImmExt;
    logic [XLEN-1:0] out_pc;
    logic            out_illegal;

    modport master (
        output in_valid, instr, ImmSrc, in_pc, out_ready,
        input  in_ready, out_valid, ImmExt, out_pc, out_illegal
    );

    modport slave (
        input  in_valid, instr, ImmSrc, in_pc, out_ready,
        output in_ready, out_valid, ImmExt, out_pc, out_illegal
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate generator with PC passthrough; IMM_CSR_ZIMM_EN enables CSR zimm on ImmSrc=110.
// Latency: 1 cycle from input transfer to out_valid when the buffer is empty.
// Backpressure: output register plus skid register; in_ready is registered (!skid full), never combinational on out_ready.
module imm_gen_pipe #(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    imm_gen_pipe_if.slave bus
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_gen_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    logic [XLEN-1:0] dec_imm;
    logic            dec_ill;

    // instr holds instruction bits [31:7], so instruction bit n lives at instr[n-7].
    always_comb begin
        dec_imm = '0;
        dec_ill = 1'b0;
        unique case (bus.ImmSrc)
            3'b000: dec_imm = XLEN'($signed(bus.instr[24:13]));
            3'b001: dec_imm = XLEN'($signed({bus.instr[24:18], bus.instr[4:0]}));
            3'b010: dec_imm = XLEN'($signed({bus.instr[24], bus.instr[0], bus.instr[23:18],
                                              bus.instr[4:1], 1'b0}));
            3'b011: dec_imm = XLEN'($signed({bus.instr[24], bus.instr[12:5], bus.instr[13],
                                              bus.instr[23:14], 1'b0}));
            3'b100: dec_imm = XLEN'($signed({bus.instr[24:5], 12'b0}));
            3'b101: begin
                if (XLEN == 64) dec_imm = XLEN'(bus.instr[18:13]);
                else            dec_imm = XLEN'(bus.instr[17:13]);
            end
            3'b110: begin
`ifdef IMM_CSR_ZIMM_EN
                dec_imm = XLEN'(bus.instr[12:8]);
`else
                dec_ill = 1'b1;
`endif
            end
            default: dec_ill = 1'b1;
        endcase
    end

    logic            out_vld;
    logic [XLEN-1:0] out_imm_dat;
    logic [XLEN-1:0] out_pc_dat;
    logic            out_ill_dat;
    logic            skid_vld;
    logic [XLEN-1:0] skid_imm_dat;
    logic [XLEN-1:0] skid_pc_dat;
    logic            skid_ill_dat;

    logic in_fire;
    logic out_free;

    assign in_fire  = bus.in_valid && !skid_vld;
    // The output slot is free after this edge if it is empty or being drained.
    assign out_free = !out_vld || bus.out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_vld      <= 1'b0;
            out_imm_dat  <= '0;
            out_pc_dat   <= '0;
            out_ill_dat  <= 1'b0;
            skid_vld     <= 1'b0;
            skid_imm_dat <= '0;
            skid_pc_dat  <= '0;
            skid_ill_dat <= 1'b0;
        end else if (flush) begin
            out_vld  <= 1'b0;
            skid_vld <= 1'b0;
        end else if (out_free) begin
            if (skid_vld) begin
                out_vld     <= 1'b1;
                out_imm_dat <= skid_imm_dat;
                out_pc_dat  <= skid_pc_dat;
                out_ill_dat <= skid_ill_dat;
                skid_vld    <= 1'b0;
            end else if (in_fire) begin
                out_vld     <= 1'b1;
                out_imm_dat <= dec_imm;
                out_pc_dat  <= bus.in_pc;
                out_ill_dat <= dec_ill;
            end else begin
                out_vld <= 1'b0;
            end
        end else if (in_fire) begin
            // Output is stalled: park the new word behind it.
            skid_vld     <= 1'b1;
            skid_imm_dat <= dec_imm;
            skid_pc_dat  <= bus.in_pc;
            skid_ill_dat <= dec_ill;
        end
    end

    assign bus.in_ready    = !skid_vld;
    assign bus.out_valid   = out_vld;
    assign bus.ImmExt      = out_imm_dat;
    assign bus.out_pc      = out_pc_dat;
    assign bus.out_illegal = out_ill_dat;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: directed format/backpressure/flush/reset scenarios plus randomized traffic vs a queue model.
module tb_imm_gen_pipe;

    logic clk;
    logic reset_n;
    logic flush;
    int   errors;
    int   checks;

    imm_gen_pipe_if #(.XLEN(32)) b ();
    imm_gen_pipe_if #(.XLEN(64)) b64 ();

    imm_gen_pipe #(.XLEN(32)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .flush  (flush),
        .bus    (b)
    );

    imm_gen_pipe #(.XLEN(64)) dut64 (
        .clk    (clk),
        .reset_n(reset_n),
        .flush  (flush),
        .bus    (b64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] imm;
        logic [63:0] pc;
        logic        ill;
    } exp_t;

    // Reference: rebuild each immediate from the full 32-bit instruction word by shifts and masks.
    function automatic exp_t model(input logic [31:0] w, input logic [2:0] src,
                                   input logic [63:0] pc, input bit x64);
        exp_t   e;
        longint s;
        s     = longint'($signed(w));
        e.imm = 64'd0;
        e.ill = 1'b0;
        e.pc  = pc;
        case (src)
            3'd0: e.imm = s >>> 20;
            3'd1: e.imm = ((s >>> 25) << 5) | 64'(w[11:7]);
            3'd2: e.imm = ((s >>> 31) << 12) | (64'(w[7]) << 11) | (64'(w[30:25]) << 5)
                          | (64'(w[11:8]) << 1);
            3'd3: e.imm = ((s >>> 31) << 20) | (64'(w[19:12]) << 12) | (64'(w[20]) << 11)
                          | (64'(w[30:21]) << 1);
            3'd4: e.imm = s & ~64'hFFF;
            3'd5: e.imm = x64 ? 64'((w >> 20) & 32'h3F) : 64'((w >> 20) & 32'h1F);
            3'd6: begin
`ifdef IMM_CSR_ZIMM_EN
                e.imm = 64'((w >> 15) & 32'h1F);
`else
                e.ill = 1'b1;
`endif
            end
            default: e.ill = 1'b1;
        endcase
        if (!x64) begin
            e.imm = {32'd0, e.imm[31:0]};
            e.pc  = {32'd0, pc[31:0]};
        end
        return e;
    endfunction

    task automatic idle();
        b.in_valid  = 1'b0;
        b.instr     = '0;
        b.ImmSrc    = '0;
        b.in_pc     = '0;
        b.out_ready = 1'b0;
    endtask

    task automatic drive(input logic [31:0] w, input logic [2:0] src, input logic [31:0] pc);
        b.in_valid = 1'b1;
        b.instr    = w[31:7];
        b.ImmSrc   = src;
        b.in_pc    = pc;
    endtask

    task automatic test_reset();
        checks++; if (b.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", b.out_valid); end
        checks++; if (b.ImmExt !== 32'd0) begin errors++; $display("FAIL reset_ImmExt got=%h want=0", b.ImmExt); end
        checks++; if (b.out_pc !== 32'd0) begin errors++; $display("FAIL reset_out_pc got=%h want=0", b.out_pc); end
        checks++; if (b.out_illegal !== 1'b0) begin errors++; $display("FAIL reset_out_illegal got=%b want=0", b.out_illegal); end
        checks++; if (b.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", b.in_ready); end
    endtask

    task automatic test_formats();
        logic [31:0] words [8];
        logic [2:0]  srcs  [8];
        logic [31:0] exps  [8];
        logic        ills  [8];
        words = '{32'hFFF00093, 32'hFE000EE3, 32'hFE000EE3, 32'h008000EF,
                  32'h123450B7, 32'h01F0D093, 32'h000A8000, 32'h000A8000};
        srcs  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
`ifdef IMM_CSR_ZIMM_EN
        exps  = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFC, 32'h00000008,
                  32'h12345000, 32'h0000001F, 32'h00000015, 32'h00000000};
        ills  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
        exps  = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFC, 32'h00000008,
                  32'h12345000, 32'h0000001F, 32'h00000000, 32'h00000000};
        ills  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`endif
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            b.out_ready = 1'b1;
            drive(words[i], srcs[i], 32'h100 + 32'(i * 4));
            @(negedge clk);
            b.in_valid = 1'b0;
            checks++; if (b.out_valid !== 1'b1) begin errors++; $display("FAIL fmt%0d_out_valid got=%b want=1", i, b.out_valid); end
            checks++; if (b.ImmExt !== exps[i]) begin errors++; $display("FAIL fmt%0d_ImmExt got=%h want=%h", i, b.ImmExt, exps[i]); end
            checks++; if (b.out_pc !== 32'h100 + 32'(i * 4)) begin errors++; $display("FAIL fmt%0d_out_pc got=%h want=%h", i, b.out_pc, 32'h100 + 32'(i * 4)); end
            checks++; if (b.out_illegal !== ills[i]) begin errors++; $display("FAIL fmt%0d_out_illegal got=%b want=%b", i, b.out_illegal, ills[i]); end
            @(negedge clk);
            checks++; if (b.out_valid !== 1'b0) begin errors++; $display("FAIL fmt%0d_single_transfer got=%b want=0", i, b.out_valid); end
        end
        idle();
    endtask

    task automatic test_xlen64();
        logic [31:0] words [2];
        logic [63:0] exps  [2];
        words = '{32'h80000037, 32'h03F0D093};
        exps  = '{64'hFFFFFFFF80000000, 64'h000000000000003F};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            b64.out_ready = 1'b1;
            b64.in_valid  = 1'b1;
            b64.instr     = words[i][31:7];
            b64.ImmSrc    = (i == 0) ? 3'd4 : 3'd5;
            b64.in_pc     = 64'h0000_0001_0000_0000 + 64'(i);
            @(negedge clk);
            b64.in_valid = 1'b0;
            checks++; if (b64.out_valid !== 1'b1) begin errors++; $display("FAIL x64_%0d_out_valid got=%b want=1", i, b64.out_valid); end
            checks++; if (b64.ImmExt !== exps[i]) begin errors++; $display("FAIL x64_%0d_ImmExt got=%h want=%h", i, b64.ImmExt, exps[i]); end
            checks++; if (b64.out_pc !== 64'h0000_0001_0000_0000 + 64'(i)) begin errors++; $display("FAIL x64_%0d_out_pc got=%h", i, b64.out_pc); end
        end
        @(negedge clk);
        b64.out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        b.out_ready = 1'b0;
        drive(32'h7FF00093, 3'd0, 32'h200);                 // A: I-type 0x7FF
        @(negedge clk);
        checks++; if (b.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_A got=%b want=1", b.in_ready); end
        drive(32'h80000037, 3'd4, 32'h204);                 // B: U-type 0x80000000
        @(negedge clk);
        checks++; if (b.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_after_B got=%b want=0", b.in_ready); end
        checks++; if (b.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid got=%b want=1", b.out_valid); end
        drive(32'h008000EF, 3'd3, 32'h208);                 // C: J-type 8, held upstream
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (b.ImmExt !== 32'h7FF) begin errors++; $display("FAIL bp_stall%0d_ImmExt got=%h want=7ff", i, b.ImmExt); end
            checks++; if (b.out_pc !== 32'h200) begin errors++; $display("FAIL bp_stall%0d_out_pc got=%h want=200", i, b.out_pc); end
            checks++; if (b.in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall%0d_in_ready got=%b want=0", i, b.in_ready); end
        end
        @(negedge clk);
        b.out_ready = 1'b1;
        checks++; if (b.ImmExt !== 32'h7FF) begin errors++; $display("FAIL bp_out_A got=%h want=7ff", b.ImmExt); end
        @(negedge clk);
        checks++; if (b.ImmExt !== 32'h80000000) begin errors++; $display("FAIL bp_out_B got=%h want=80000000", b.ImmExt); end
        checks++; if (b.out_pc !== 32'h204) begin errors++; $display("FAIL bp_out_B_pc got=%h want=204", b.out_pc); end
        checks++; if (b.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_reopen got=%b want=1", b.in_ready); end
        @(negedge clk);
        b.in_valid = 1'b0;
        checks++; if (b.ImmExt !== 32'h8) begin errors++; $display("FAIL bp_out_C got=%h want=8", b.ImmExt); end
        checks++; if (b.out_pc !== 32'h208) begin errors++; $display("FAIL bp_out_C_pc got=%h want=208", b.out_pc); end
        @(negedge clk);
        checks++; if (b.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got=%b want=0", b.out_valid); end
        idle();
    endtask

    task automatic test_flush();
        @(negedge clk);
        b.out_ready = 1'b0;
        drive(32'h00100093, 3'd0, 32'h300);
        @(negedge clk);
        drive(32'h00200093, 3'd0, 32'h304);
        @(negedge clk);
        drive(32'hABCDE037, 3'd4, 32'h308);
        checks++; if (b.in_ready !== 1'b0) begin errors++; $display("FAIL flush_full_in_ready got=%b want=0", b.in_ready); end
        flush = 1'b1;
        @(negedge clk);
        flush      = 1'b0;
        b.in_valid = 1'b0;
        checks++; if (b.out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got=%b want=0", b.out_valid); end
        checks++; if (b.in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got=%b want=1", b.in_ready); end
        b.out_ready = 1'b1;
        // An input transfer coinciding with flush must also vanish.
        drive(32'h12300093, 3'd0, 32'h30C);
        flush = 1'b1;
        @(negedge clk);
        flush      = 1'b0;
        b.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (b.out_valid !== 1'b0) begin errors++; $display("FAIL flush_quiet%0d got=%b want=0", i, b.out_valid); end
            @(negedge clk);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        b.out_ready = 1'b0;
        drive(32'h00500093, 3'd0, 32'h400);
        @(negedge clk);
        drive(32'h00600093, 3'd0, 32'h404);
        @(negedge clk);
        b.in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checks++; if (b.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid got=%b want=0", b.out_valid); end
        checks++; if (b.in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready got=%b want=1", b.in_ready); end
        checks++; if (b.ImmExt !== 32'd0) begin errors++; $display("FAIL rst_mid_ImmExt got=%h want=0", b.ImmExt); end
        @(negedge clk);
        reset_n     = 1'b1;
        b.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (b.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_quiet%0d got=%b want=0", i, b.out_valid); end
        end
        idle();
    endtask

    task automatic test_random();
        exp_t        q[$];
        exp_t        e;
        logic [31:0] w;
        logic [31:0] last_imm;
        logic [31:0] last_pc;
        logic        last_ill;
        bit          stalled;
        int          drain;
        stalled = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (stalled) begin
                checks++;
                if (b.ImmExt !== last_imm || b.out_pc !== last_pc || b.out_illegal !== last_ill) begin
                    errors++;
                    $display("FAIL rnd_stable cyc=%0d got=%h/%h/%b want=%h/%h/%b", cyc,
                             b.ImmExt, b.out_pc, b.out_illegal, last_imm, last_pc, last_ill);
                end
            end
            checks++; if (b.out_valid !== (q.size() > 0)) begin errors++; $display("FAIL rnd_out_valid cyc=%0d got=%b want=%b", cyc, b.out_valid, q.size() > 0); end
            checks++; if (b.in_ready !== (q.size() < 2)) begin errors++; $display("FAIL rnd_in_ready cyc=%0d got=%b want=%b", cyc, b.in_ready, q.size() < 2); end
            w = $urandom;
            b.in_valid  = ($urandom_range(0, 3) != 0);
            b.instr     = w[31:7];
            b.ImmSrc    = 3'($urandom_range(0, 7));
            b.in_pc     = $urandom;
            b.out_ready = ($urandom_range(0, 2) != 0);
            if (b.out_valid && b.out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rnd_unexpected_out cyc=%0d got=%h want=none", cyc, b.ImmExt);
                end else begin
                    e = q.pop_front();
                    if (b.ImmExt !== e.imm[31:0] || b.out_pc !== e.pc[31:0] || b.out_illegal !== e.ill) begin
                        errors++;
                        $display("FAIL rnd_data cyc=%0d got=%h/%h/%b want=%h/%h/%b", cyc,
                                 b.ImmExt, b.out_pc, b.out_illegal, e.imm[31:0], e.pc[31:0], e.ill);
                    end
                end
            end
            if (b.in_valid && b.in_ready)
                q.push_back(model(w, b.ImmSrc, {32'd0, b.in_pc}, 1'b0));
            stalled  = b.out_valid && !b.out_ready;
            last_imm = b.ImmExt;
            last_pc  = b.out_pc;
            last_ill = b.out_illegal;
        end
        @(negedge clk);
        b.in_valid  = 1'b0;
        b.out_ready = 1'b1;
        drain = 0;
        while (q.size() > 0 && drain < 10) begin
            checks++;
            e = q.pop_front();
            if (b.out_valid !== 1'b1 || b.ImmExt !== e.imm[31:0] || b.out_pc !== e.pc[31:0]) begin
                errors++;
                $display("FAIL rnd_drain got=%b/%h/%h want=1/%h/%h", b.out_valid, b.ImmExt, b.out_pc,
                         e.imm[31:0], e.pc[31:0]);
            end
            @(negedge clk);
            drain++;
        end
        checks++; if (b.out_valid !== 1'b0) begin errors++; $display("FAIL rnd_empty_after_drain got=%b want=0", b.out_valid); end
        idle();
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        reset_n = 1'b0;
        flush   = 1'b0;
        idle();
        b64.in_valid  = 1'b0;
        b64.instr     = '0;
        b64.ImmSrc    = '0;
        b64.in_pc     = '0;
        b64.out_ready = 1'b0;
        #1;
        test_reset();
        @(negedge clk);
        reset_n = 1'b1;
        test_formats();
        test_xlen64();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
